fifo_traffic_gen_mc: RTL and testbench

// - Synthesizable, parametrised successor to the FIFO testbench traffic generator.
// - Drives NUM_CH independent FIFO-under-test push ports and the shared grant_in bandwidth control.
// - Runs a commanded mode: FILL, DRAIN or RANDOM (timed, rate-throttled).
// - Items are self-describing {parity, ch_id, seq}, so a scoreboard checks order and parity with no side channel.

---
 rtl/fifo_traffic_gen_mc_pkg.sv | 40 ++++
 rtl/fifo_traffic_gen_mc_if.sv | 12 +
 rtl/fifo_traffic_gen_mc_channel.sv | 62 ++++++
 rtl/fifo_traffic_gen_mc.sv | 147 ++++++++++++++
 tb/tb_fifo_traffic_gen_mc.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_traffic_gen_mc_pkg.sv
// rtl/fifo_traffic_gen_mc_pkg.sv - shared types and constants for the FIFO traffic generator
package fifo_tb_pkg;

  typedef enum logic [2:0] {
    BW_000 = 3'd0,
    BW_025 = 3'd1,
    BW_050 = 3'd2,
    BW_075 = 3'd3,
    BW_100 = 3'd4
  } grant_in_e;

  typedef enum logic [1:0] {
    MODE_FILL   = 2'd0,
    MODE_DRAIN  = 2'd1,
    MODE_RANDOM = 2'd2
  } gen_mode_e;

  // Encoded so that "lfsr[1:0] <= rate" selects 1, 2, 3 or 4 of the 4 LFSR values
  typedef enum logic [1:0] {
    RATE_025 = 2'd0,
    RATE_050 = 2'd1,
    RATE_075 = 2'd2,
    RATE_100 = 2'd3
  } tx_rate_e;

  typedef logic [2:0] gen_state_e;
  localparam gen_state_e ST_IDLE  = 3'd0;
  localparam gen_state_e ST_FILL  = 3'd1;
  localparam gen_state_e ST_DRAIN = 3'd2;
  localparam gen_state_e ST_RAND  = 3'd3;
  localparam gen_state_e ST_DONE  = 3'd4;

  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_traffic_gen_mc_if.sv
// rtl/fifo_traffic_gen_mc_if.sv - per-channel FIFO push ports driven by the generator
interface fifo_traffic_gen_mc_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 17
);
  logic [NUM_CH-1:0]            valid_in;
  logic [NUM_CH*DATA_WIDTH-1:0] data_in;
  logic [NUM_CH-1:0]            grant_out;

  modport master (output valid_in, output data_in, input grant_out);
  modport slave  (input valid_in, input data_in, output grant_out);
endinterface

// File: rtl/fifo_traffic_gen_mc_channel.sv
// rtl/fifo_traffic_gen_mc_channel.sv - one push port: holds valid/data, counts seq, builds parity
module fifo_gen_channel #(
  parameter int DATA_WIDTH = 17,
  parameter int CH_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  grant,
  input  logic                  offer,
  input  logic                  flush,
  input  logic                  inject,
  input  logic [CH_BITS-1:0]    ch_id,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  xfer
);
  localparam int SEQ_BITS = DATA_WIDTH - 1 - CH_BITS;

  logic                  valid_q, valid_d;
  logic                  inj_q, inj_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEQ_BITS-1:0]   seq_q, seq_d;
  logic [DATA_WIDTH-2:0] payload;
  logic                  present;

  assign xfer  = valid_q & grant;
  assign valid = valid_q;
  assign data  = data_q;

  always_comb begin
    seq_d   = seq_q + SEQ_BITS'(xfer);
    // The flag stays armed until the item actually carrying the flipped parity is accepted
    inj_d   = inject | (inj_q & ~(xfer & err_q));
    payload = {ch_id, seq_d};
    present = (xfer | ~valid_q) & offer & ~flush;
    valid_d = present | (valid_q & ~xfer & ~flush);
    data_d  = data_q;
    err_d   = err_q;
    if (present) begin
      data_d = {(^payload) ^ inj_d, payload};
      err_d  = inj_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      seq_q   <= '0;
      inj_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      seq_q   <= seq_d;
      inj_q   <= inj_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/fifo_traffic_gen_mc.sv
// rtl/fifo_traffic_gen_mc.sv - multi-channel FIFO traffic generator: FSM, throttle LFSR, counters
module fifo_traffic_gen_mc
  import fifo_tb_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter int          DATA_WIDTH = 17,
  parameter int          DUR_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  gen_mode_e            mode,
  input  grant_in_e            bw,
  input  tx_rate_e             tx_rate,
  input  logic [DUR_WIDTH-1:0] duration,
  input  logic                 inject_err,
  fifo_traffic_gen_mc_if.master push,
  output grant_in_e            grant_in_ctrl,
  output logic                 busy,
  output logic                 done
);
  localparam int CH_BITS = ch_bits(NUM_CH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  gen_state_e           state_q, state_d;
  grant_in_e            bw_q, bw_d, grant_ctrl_q, grant_ctrl_d;
  tx_rate_e             rate_q, rate_d;
  logic [DUR_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]     fill_q [NUM_CH];
  logic [CNT_W-1:0]     fill_d [NUM_CH];
  logic [CNT_W-1:0]     fill_nxt [NUM_CH];
  logic                 all_full, keep, flush;
  logic [NUM_CH-1:0]    offer, xfer, ch_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data;

  always_comb begin
    state_d  = state_q;
    bw_d     = bw_q;
    rate_d   = rate_q;
    cnt_d    = cnt_q;
    lfsr_d   = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    all_full = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      fill_nxt[c] = fill_q[c] + CNT_W'(xfer[c]);
      if (fill_nxt[c] != CNT_W'(FIFO_DEPTH)) all_full = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          bw_d   = bw;
          rate_d = tx_rate;
          case (mode)
            MODE_FILL:  state_d = ST_FILL;
            MODE_DRAIN: begin
              state_d = ST_DRAIN;
              cnt_d   = DUR_WIDTH'(FIFO_DEPTH);
            end
            default: begin
              cnt_d   = duration;
              state_d = (duration == '0) ? ST_DONE : ST_RAND;
            end
          endcase
        end
      end
      ST_FILL: if (all_full) state_d = ST_DONE;
      ST_DRAIN, ST_RAND: begin
        cnt_d = cnt_q - DUR_WIDTH'(1);
        if (cnt_q <= DUR_WIDTH'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;

    for (int c = 0; c < NUM_CH; c++)
      fill_d[c] = (state_q == ST_FILL) ? fill_nxt[c] : '0;

    // New items only while staying in a pushing state; any exit or abort drops valid that edge
    keep  = (state_d == state_q) && (state_q == ST_FILL || state_q == ST_RAND);
    flush = !keep;
    for (int c = 0; c < NUM_CH; c++)
      offer[c] = keep && ((state_q == ST_FILL) ? (fill_nxt[c] < CNT_W'(FIFO_DEPTH))
                                               : (lfsr_q[1:0] <= rate_q));

    case (state_d)
      ST_FILL: grant_ctrl_d = BW_000;
      ST_RAND: grant_ctrl_d = bw_d;
      default: grant_ctrl_d = BW_100;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bw_q         <= BW_100;
      rate_q       <= RATE_100;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      grant_ctrl_q <= BW_100;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) fill_q[c] <= '0;
    end else begin
      state_q      <= state_d;
      bw_q         <= bw_d;
      rate_q       <= rate_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      grant_ctrl_q <= grant_ctrl_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      for (int c = 0; c < NUM_CH; c++) fill_q[c] <= fill_d[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_gen_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .CH_BITS    (CH_BITS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .grant  (push.grant_out[c]),
      .offer  (offer[c]),
      .flush  (flush),
      .inject (inject_err),
      .ch_id  (CH_BITS'(c)),
      .valid  (ch_valid[c]),
      .data   (ch_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .xfer   (xfer[c])
    );
  end

  assign push.valid_in  = ch_valid;
  assign push.data_in   = ch_data;
  assign grant_in_ctrl  = grant_ctrl_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_fifo_traffic_gen_mc.sv
// tb/tb_fifo_traffic_gen_mc.sv - directed self-checking bench for fifo_traffic_gen_mc
module tb_fifo_traffic_gen_mc;
  import fifo_tb_pkg::*;

  localparam int NCH = 2;
  localparam int DW  = 17;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, inject_err = 1'b0;
  gen_mode_e  mode = MODE_FILL;
  grant_in_e  bw = BW_100;
  tx_rate_e   tx_rate = RATE_100;
  logic [15:0] duration = 16'd0;
  grant_in_e  grant_in_ctrl;
  logic       busy, done;

  fifo_traffic_gen_mc_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) push ();

  fifo_traffic_gen_mc #(
    .NUM_CH(NCH), .FIFO_DEPTH(4), .DATA_WIDTH(DW), .DUR_WIDTH(16), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .bw(bw),
    .tx_rate(tx_rate), .duration(duration), .inject_err(inject_err), .push(push),
    .grant_in_ctrl(grant_in_ctrl), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] xlog [NCH][1024];
  int xn [NCH];
  int xfirst [NCH];
  int xlast [NCH];
  int seq_base [NCH];
  int edge_n;
  int done_cnt;

  function automatic logic [DW-1:0] exp_item(input int ch, input int seq);
    logic [DW-2:0] p;
    p = {ch[0], seq[14:0]};
    return {^p, p};
  endfunction

  task automatic tick();
    for (int c = 0; c < NCH; c++)
      if (!rst && push.valid_in[c] && push.grant_out[c]) begin
        if (xn[c] < 1024) xlog[c][xn[c]] = push.data_in[c*DW +: DW];
        if (xn[c] == 0) xfirst[c] = edge_n + 1;
        xlast[c] = edge_n + 1;
        xn[c]++;
      end
    @(posedge clk);
    #1;
    edge_n++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic clear_log();
    for (int c = 0; c < NCH; c++) begin
      xn[c] = 0; xfirst[c] = -1; xlast[c] = -1;
    end
    edge_n = 0;
    done_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (push.valid_in !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b want=00", push.valid_in); end
    checks++; if (push.data_in !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", push.data_in); end
    checks++; if (grant_in_ctrl !== BW_100) begin failures++; $display("FAIL reset_bw got=%0d want=%0d", grant_in_ctrl, BW_100); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    for (int c = 0; c < NCH; c++) seq_base[c] = 0;
  endtask

  task automatic check_fill_items(input string tag);
    for (int c = 0; c < NCH; c++) begin
      checks++; if (xn[c] != 4) begin failures++; $display("FAIL %s_count ch%0d got=%0d want=4", tag, c, xn[c]); end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (xlog[c][k] !== exp_item(c, seq_base[c] + k)) begin
          failures++; $display("FAIL %s_item ch%0d k=%0d got=%h want=%h", tag, c, k, xlog[c][k], exp_item(c, seq_base[c] + k));
        end
      end
      seq_base[c] += xn[c];
    end
  endtask

  task automatic test_fill();
    clear_log();
    push.grant_out = 2'b11; mode = MODE_FILL; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (grant_in_ctrl !== BW_000) begin failures++; $display("FAIL fill_bw got=%0d want=%0d", grant_in_ctrl, BW_000); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fill_busy got=%b want=1", busy); end
    for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL fill_done got=%b want=1", done); end
    checks++; if (edge_n != xlast[0]) begin failures++; $display("FAIL fill_done_cycle got=%0d want=%0d", edge_n, xlast[0]); end
    for (int c = 0; c < NCH; c++) begin
      checks++; if (xlast[c] - xfirst[c] != 3) begin failures++; $display("FAIL fill_b2b ch%0d got=%0d want=3", c, xlast[c] - xfirst[c]); end
    end
    check_fill_items("fill");
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL fill_idle got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_fill_stall();
    logic [DW-1:0] held;
    clear_log();
    push.grant_out = 2'b11; mode = MODE_FILL; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    push.grant_out = 2'b10;
    held = push.data_in[0 +: DW];
    checks++; if (held !== exp_item(0, seq_base[0] + 1)) begin failures++; $display("FAIL stall_item got=%h want=%h", held, exp_item(0, seq_base[0] + 1)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (push.valid_in[0] !== 1'b1 || push.data_in[0 +: DW] !== held) begin
        failures++; $display("FAIL stall_hold i=%0d got v=%b d=%h want v=1 d=%h", i, push.valid_in[0], push.data_in[0 +: DW], held);
      end
    end
    push.grant_out = 2'b11;
    for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b want=1", done); end
    check_fill_items("stall");
    tick();
  endtask

  task automatic test_drain();
    int n, vbad, bwbad;
    clear_log();
    push.grant_out = 2'b11; mode = MODE_DRAIN; start = 1'b1;
    vbad = 0; bwbad = 0; n = 0;
    tick(); n++;
    start = 1'b0;
    while (done !== 1'b1 && n < 20) begin
      if (push.valid_in !== 2'b00) vbad++;
      if (grant_in_ctrl !== BW_100) bwbad++;
      tick(); n++;
    end
    checks++; if (n != 5) begin failures++; $display("FAIL drain_done_cycle got=%0d want=5", n); end
    checks++; if (vbad != 0) begin failures++; $display("FAIL drain_valid got=%0d want=0", vbad); end
    checks++; if (bwbad != 0) begin failures++; $display("FAIL drain_bw got=%0d want=0", bwbad); end
    tick();
  endtask

  task automatic test_random();
    int n, bwbad, bad;
    clear_log();
    push.grant_out = 2'b11; mode = MODE_RANDOM; bw = BW_050; tx_rate = RATE_050; duration = 16'd1000;
    start = 1'b1; n = 0; bwbad = 0;
    tick(); n++;
    start = 1'b0;
    while (done !== 1'b1 && n < 1100) begin
      if (grant_in_ctrl !== BW_050) bwbad++;
      tick(); n++;
    end
    checks++; if (n != 1001) begin failures++; $display("FAIL rand_done_cycle got=%0d want=1001", n); end
    checks++; if (bwbad != 0) begin failures++; $display("FAIL rand_bw got=%0d want=0", bwbad); end
    for (int c = 0; c < NCH; c++) begin
      checks++; if (xn[c] < 400 || xn[c] > 600) begin failures++; $display("FAIL rand_count ch%0d got=%0d want=400..600", c, xn[c]); end
      bad = 0;
      for (int k = 0; k < xn[c] && k < 1024; k++)
        if (xlog[c][k] !== exp_item(c, seq_base[c] + k)) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL rand_items ch%0d got=%0d bad want=0", c, bad); end
      seq_base[c] += xn[c];
    end
    tick();
  endtask

  task automatic test_inject();
    int odd, bad;
    logic [DW-1:0] e;
    clear_log();
    push.grant_out = 2'b11; mode = MODE_RANDOM; bw = BW_025; tx_rate = RATE_075; duration = 16'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    inject_err = 1'b1;
    tick();
    inject_err = 1'b0;
    for (int i = 0; i < 300 && done !== 1'b1; i++) tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL inj_done got=%b want=1", done); end
    for (int c = 0; c < NCH; c++) begin
      odd = 0; bad = 0;
      for (int k = 0; k < xn[c] && k < 1024; k++) begin
        e = exp_item(c, seq_base[c] + k);
        if (xlog[c][k][DW-2:0] !== e[DW-2:0]) bad++;
        if (^xlog[c][k]) odd++;
      end
      checks++; if (odd != 1) begin failures++; $display("FAIL inj_odd ch%0d got=%0d want=1", c, odd); end
      checks++; if (bad != 0) begin failures++; $display("FAIL inj_payload ch%0d got=%0d bad want=0", c, bad); end
      seq_base[c] += xn[c];
    end
    tick();
  endtask

  task automatic test_dur_zero();
    clear_log();
    mode = MODE_RANDOM; bw = BW_075; tx_rate = RATE_100; duration = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL dur0_done got done=%b busy=%b want 1 1", done, busy); end
    checks++; if (push.valid_in !== 2'b00) begin failures++; $display("FAIL dur0_valid got=%b want=00", push.valid_in); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL dur0_idle got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_abort_reset();
    clear_log();
    push.grant_out = 2'b11; mode = MODE_RANDOM; bw = BW_075; tx_rate = RATE_100; duration = 16'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (push.valid_in !== 2'b00) begin failures++; $display("FAIL abort_valid got=%b want=00", push.valid_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (grant_in_ctrl !== BW_100) begin failures++; $display("FAIL abort_bw got=%0d want=%0d", grant_in_ctrl, BW_100); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end

    mode = MODE_FILL; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_abort_busy got=%b want=0", busy); end
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (push.valid_in !== 2'b00) begin failures++; $display("FAIL rst_valid got=%b want=00", push.valid_in); end
    checks++; if (push.data_in !== '0) begin failures++; $display("FAIL rst_data got=%h want=0", push.data_in); end
    checks++; if (grant_in_ctrl !== BW_100) begin failures++; $display("FAIL rst_bw got=%0d want=%0d", grant_in_ctrl, BW_100); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_flags got busy=%b done=%b want 0 0", busy, done); end
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) seq_base[c] = 0;

    clear_log();
    start = 1'b1; mode = MODE_FILL;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rst_refill_done got=%b want=1", done); end
    check_fill_items("rst_refill");
    tick();
  endtask

  initial begin
    push.grant_out = 2'b00;
    clear_log();
    test_reset();
    test_fill();
    test_fill_stall();
    test_drain();
    test_random();
    test_inject();
    test_dur_zero();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
